// File: rtl/sa_max_result_drain.sv
// Result drain for one column of max PEs: pulse result_load, snapshot the
// column's c_out values, then stream them out one row per valid/ready beat.
module sa_max_result_drain #(
    parameter  int unsigned OC_W  = 16,
    parameter  int unsigned ROWS  = 8,
    localparam int unsigned ROW_W = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 window_done,
    input  logic [ROWS*OC_W-1:0] c_in,
    output logic                 result_load,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OC_W-1:0]      out_data,
    output logic [ROW_W-1:0]     out_row,
    output logic                 out_last,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CAPT   = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ROW_W-1:0] row;
    logic             pending;
    logic [OC_W-1:0]  buffer [ROWS];

    logic             beat_taken;
    logic             final_beat;
    logic             ovr_event;

    // Handshake and error-event decode shared by next-state and datapath.
    always_comb begin
        beat_taken = (state == STREAM) && out_ready;
        final_beat = beat_taken && (row == LAST_ROW);
        ovr_event  = window_done &&
                     ((state == LOAD) || (state == CAPT) ||
                      ((state == STREAM) && pending));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a request landing on the final beat reloads directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (window_done) state_nxt = LOAD;
            LOAD:    state_nxt = CAPT;
            CAPT:    state_nxt = STREAM;
            STREAM:  if (final_beat) state_nxt = (pending || window_done) ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from the state register and the held snapshot.
    always_comb begin
        result_load = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_row     = row;
        out_data    = buffer[row];
        busy        = (state != IDLE) || pending;
        case (state)
            LOAD:    result_load = 1'b1;
            STREAM: begin
                out_valid = 1'b1;
                out_last  = (row == LAST_ROW);
            end
            default: ;
        endcase
    end

    // Snapshot buffer, row counter, queued request and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
            for (int r = 0; r < int'(ROWS); r++) begin
                buffer[r] <= '0;
            end
        end else begin
            if (state == CAPT) begin
                for (int r = 0; r < int'(ROWS); r++) begin
                    buffer[r] <= c_in[r*OC_W +: OC_W];
                end
                row <= '0;
            end else if (beat_taken) begin
                row <= final_beat ? '0 : row + ROW_W'(1);
            end

            // Final beat consumes a queued request, or absorbs a coincident one.
            if (final_beat) begin
                pending <= 1'b0;
            end else if ((state == STREAM) && window_done) begin
                pending <= 1'b1;
            end

            if (ovr_event) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sa_max_result_drain.sv
// Bench for sa_max_result_drain (ROWS=4): directed scenarios then random
// traffic, all compared cycle by cycle against a window-level model.
module tb_sa_max_result_drain;

    localparam int unsigned OC_W  = 16;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned ROW_W = $clog2(ROWS);

    logic                 clk;
    logic                 rst_n;
    logic                 window_done;
    logic [ROWS*OC_W-1:0] c_in;
    logic                 result_load;
    logic                 out_valid;
    logic                 out_ready;
    logic [OC_W-1:0]      out_data;
    logic [ROW_W-1:0]     out_row;
    logic                 out_last;
    logic                 busy;
    logic                 overrun;
    logic                 overrun_clr;

    sa_max_result_drain #(.OC_W(OC_W), .ROWS(ROWS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .window_done (window_done),
        .c_in        (c_in),
        .result_load (result_load),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int beats_seen = 0;

    // Model: an active window walks load cycle (k=0), capture cycle (k=1),
    // then streams (k=2) beat by beat from its snapshot.
    bit              m_act;
    int              m_k;
    int              m_beat;
    bit              m_pend;
    bit              m_ovr;
    logic [OC_W-1:0] m_buf [ROWS];

    localparam logic [ROWS*OC_W-1:0] CIN_A   = {16'h7C00, 16'hC200, 16'h4000, 16'h3C00};
    localparam logic [ROWS*OC_W-1:0] CIN_B   = {16'h7E00, 16'hFC00, 16'h8000, 16'h0001};
    localparam logic [ROWS*OC_W-1:0] CIN_ONE = {64{1'b1}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = m_act && (m_k == 2);
        chk("result_load", 32'(result_load), 32'(m_act && (m_k == 0)));
        chk("out_valid",   32'(out_valid),   32'(v));
        chk("busy",        32'(busy),        32'(m_act || m_pend));
        chk("overrun",     32'(overrun),     32'(m_ovr));
        if (v) begin
            chk("out_data", 32'(out_data), 32'(m_buf[m_beat]));
            chk("out_row",  32'(out_row),  32'(m_beat));
            chk("out_last", 32'(out_last), 32'(m_beat == int'(ROWS) - 1));
        end else begin
            chk("out_last_idle", 32'(out_last), 32'd0);
        end
    endtask

    task automatic model_update(input bit rst, input bit wd, input bit rdy,
                                input bit clr, input logic [ROWS*OC_W-1:0] cin);
        bit streaming, hs, lastb, ovr_ev;
        if (rst) begin
            m_act = 0; m_k = 0; m_beat = 0; m_pend = 0; m_ovr = 0;
            foreach (m_buf[i]) m_buf[i] = '0;
            return;
        end
        streaming = m_act && (m_k == 2);
        hs        = streaming && rdy;
        lastb     = hs && (m_beat == int'(ROWS) - 1);
        ovr_ev    = wd && m_act && ((m_k < 2) || m_pend);
        if (lastb) begin
            if (m_pend || wd) m_k = 0;
            else              m_act = 0;
            m_pend = 0;
            m_beat = 0;
        end else begin
            if (streaming && wd) m_pend = 1;
            if (hs) m_beat++;
            else if (m_act && m_k == 1) begin
                for (int i = 0; i < int'(ROWS); i++) m_buf[i] = cin[i*OC_W +: OC_W];
                m_beat = 0;
                m_k    = 2;
            end else if (m_act && m_k == 0) m_k = 1;
            else if (!m_act && wd) begin
                m_act = 1;
                m_k   = 0;
            end
        end
        if (ovr_ev)   m_ovr = 1;
        else if (clr) m_ovr = 0;
    endtask

    // One clock cycle: check current outputs, apply inputs, advance the model.
    task automatic step(input bit rst, input bit wd, input bit rdy, input bit clr,
                        input logic [ROWS*OC_W-1:0] cin);
        check_outputs();
        rst_n       = !rst;
        window_done = wd;
        out_ready   = rdy;
        overrun_clr = clr;
        c_in        = cin;
        if (out_valid && rdy && !rst) beats_seen++;
        @(posedge clk);
        model_update(rst, wd, rdy, clr, cin);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n, input logic [ROWS*OC_W-1:0] cin);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, cin);
    endtask

    initial begin
        rst_n = 0; window_done = 0; out_ready = 0; overrun_clr = 0; c_in = '0;
        @(posedge clk);
        @(posedge clk);
        model_update(1, 0, 0, 0, '0);
        @(negedge clk);

        // Reset state.
        chk("rst_row", 32'(out_row), 32'd0);
        step(0, 0, 1, 0, CIN_A);

        // Basic drain with out_ready held high.
        beats_seen = 0;
        step(0, 1, 1, 0, CIN_A);
        idle_cycles(8, CIN_A);
        chk("basic_beats", 32'(beats_seen), 32'd4);

        // Backpressure: ready alternates starting at 0.
        beats_seen = 0;
        step(0, 1, 0, 0, CIN_B);
        step(0, 0, 0, 0, CIN_B);
        step(0, 0, 0, 0, CIN_B);
        for (int i = 0; i < 10; i++) step(0, 0, i[0], 0, CIN_B);
        idle_cycles(2, CIN_B);
        chk("bp_beats", 32'(beats_seen), 32'd4);

        // Capture isolation: inputs change to all-ones once streaming starts.
        step(0, 1, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        idle_cycles(6, CIN_ONE);

        // Pending back-to-back: second request on beat 1.
        beats_seen = 0;
        step(0, 1, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_B);
        step(0, 1, 1, 0, CIN_B);
        idle_cycles(10, CIN_B);
        chk("pend_beats", 32'(beats_seen), 32'd8);
        chk("pend_no_ovr", 32'(overrun), 32'd0);

        // Overrun: request in LOAD, then three requests in one stream.
        step(0, 1, 1, 0, CIN_A);
        step(0, 1, 1, 0, CIN_A);
        step(0, 0, 0, 0, CIN_A);
        step(0, 1, 0, 0, CIN_A);
        step(0, 1, 0, 0, CIN_A);
        step(0, 1, 0, 0, CIN_A);
        beats_seen = 0;
        idle_cycles(14, CIN_B);
        chk("ovr_extra_beats", 32'(beats_seen), 32'd8);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        step(0, 0, 1, 1, CIN_B);
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Reset during beat 2, then a fresh full stream.
        step(0, 1, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        step(0, 0, 1, 0, CIN_A);
        step(1, 0, 1, 0, CIN_A);
        chk("rst_mid_row", 32'(out_row), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        beats_seen = 0;
        step(0, 1, 1, 0, CIN_B);
        idle_cycles(8, CIN_B);
        chk("rst_new_beats", 32'(beats_seen), 32'd4);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [ROWS*OC_W-1:0] rc;
            rc = {$urandom, $urandom};
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 5,
                 rc);
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
